// File: rtl/tt_um_serial_addsub_if.sv
// -----------------------------------------------------------------------------
// tt_um_serial_addsub_if
//
// Purpose : Groups the standard Tiny Tapeout pin bus of the bit-serial
//           add/subtract unit so the design and its host share one handle.
//
// Signals :
//   ui_in   [7:0]  host -> design  [0] a bit, [1] b bit, [2] bit_valid,
//                                  [3] start, [4] sub, [7:5] unused
//   uo_out  [7:0]  design -> host  result register, zero-extended
//   uio_in  [7:0]  host -> design  unused
//   uio_out [7:0]  design -> host  [0] done, [1] cout/borrow, [2] busy,
//                                  [3] last sum bit, [7:4] zero
//   uio_oe  [7:0]  design -> host  output enables, constant 8'h0F
//
// Modports: master (host side), slave (design side).
// -----------------------------------------------------------------------------
interface tt_um_serial_addsub_if;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    modport master (
        output ui_in,
        output uio_in,
        input  uo_out,
        input  uio_out,
        input  uio_oe
    );

    modport slave (
        input  ui_in,
        input  uio_in,
        output uo_out,
        output uio_out,
        output uio_oe
    );
endinterface

// File: rtl/tt_um_serial_addsub.sv
// -----------------------------------------------------------------------------
// tt_um_serial_addsub
//
// Purpose : Bit-serial add/subtract unit. Operands arrive LSB-first, one bit
//           pair per clock on which bit_valid is high. After WIDTH bits the
//           WIDTH-bit sum (or difference) sits on uo_out with carry (or
//           borrow) and done on uio_out. Subtraction is a + ~b + 1, so the
//           carry chain starts at 1 and the final carry is inverted to give
//           a borrow (borrow = 1 iff a < b unsigned).
//
// Ports   :
//   clk    in  clock
//   rst_n  in  asynchronous active-low reset
//   ena    in  design enable; low freezes every register
//   bus    tt_um_serial_addsub_if.slave (ui_in/uo_out/uio_in/uio_out/uio_oe)
//
// Parameter:
//   WIDTH  operand/result width, legal 1..8
//
// Build option:
//   INPUT_SYNC_EN  when defined, ui_in[4:0] pass through a 2-flop
//                  synchronizer before any logic (adds 2 edges of latency
//                  to every input-referenced event). Undefined by default:
//                  inputs must be synchronous to clk.
// -----------------------------------------------------------------------------
module tt_um_serial_addsub #(
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ena,
    tt_um_serial_addsub_if.slave  bus
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               start_q, start_d;
    logic               mode_q, mode_d;
    logic               carry_q, carry_d;
    logic               cout_q, cout_d;
    logic               last_q, last_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   result_q, result_d;

    logic [4:0]         in_sig;
    logic               a_in, b_in, valid_in, start_in, sub_in;
    logic               start_rise;
    logic               b_eff, sum_bit, carry_next;

    // Unused pins folded into one sink so lint stays quiet.
    logic               unused_pins;
    assign unused_pins = &{1'b0, bus.uio_in, bus.ui_in[7:5]};

`ifdef INPUT_SYNC_EN
    // Two-flop synchronizer on the functional inputs; frozen by ena like
    // every other register so a stall cannot lose or invent an edge.
    logic [4:0] sync1_q, sync1_d;
    logic [4:0] sync2_q, sync2_d;

    always_comb begin
        sync1_d = sync1_q;
        sync2_d = sync2_q;
        if (ena) begin
            sync1_d = bus.ui_in[4:0];
            sync2_d = sync1_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign in_sig = sync2_q;
`else
    assign in_sig = bus.ui_in[4:0];
`endif

    assign a_in       = in_sig[0];
    assign b_in       = in_sig[1];
    assign valid_in   = in_sig[2];
    assign start_in   = in_sig[3];
    assign sub_in     = in_sig[4];
    assign start_rise = start_in & ~start_q;

    // One full-adder slice; b is inverted in subtract mode.
    assign b_eff      = b_in ^ mode_q;
    assign sum_bit    = a_in ^ b_eff ^ carry_q;
    assign carry_next = (a_in & b_eff) | (a_in & carry_q) | (b_eff & carry_q);

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            start_q  <= 1'b0;
            mode_q   <= 1'b0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            last_q   <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            start_q  <= start_d;
            mode_q   <= mode_d;
            carry_q  <= carry_d;
            cout_q   <= cout_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and datapath
    // -------------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        start_d  = start_q;
        mode_d   = mode_q;
        carry_d  = carry_q;
        cout_d   = cout_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        result_d = result_q;

        if (ena) begin
            start_d = start_in;
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    // bit_valid is ignored here; only a start edge matters.
                    if (start_rise) begin
                        state_d  = ST_BUSY;
                        mode_d   = sub_in;
                        carry_d  = sub_in;   // the "+1" of a + ~b + 1
                        cout_d   = 1'b0;
                        last_d   = 1'b0;
                        cnt_d    = '0;
                        result_d = '0;
                    end
                end
                ST_BUSY: begin
                    // Start edges are ignored while an operation runs.
                    if (valid_in) begin
                        carry_d  = carry_next;
                        last_d   = sum_bit;
                        cnt_d    = cnt_q + CNT_W'(1);
                        result_d = result_q >> 1;
                        result_d[WIDTH-1] = sum_bit;
                        if (cnt_q == CNT_W'(WIDTH - 1)) begin
                            state_d = ST_DONE;
                            // Subtract carry-out of 1 means no borrow.
                            cout_d  = mode_q ? ~carry_next : carry_next;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    always_comb begin
        bus.uo_out  = 8'(result_q);
        bus.uio_out = {4'b0000, last_q, (state_q == ST_BUSY), cout_q,
                       (state_q == ST_DONE)};
        bus.uio_oe  = 8'b0000_1111;
    end

endmodule

// File: tb/tb_tt_um_serial_addsub.sv
// -----------------------------------------------------------------------------
// tb_tt_um_serial_addsub
//
// Directed bench for tt_um_serial_addsub (default build, WIDTH = 8).
// Inputs change 1 time unit after each rising edge; outputs are sampled at
// the same point, well away from the next edge.
// -----------------------------------------------------------------------------
module tb_tt_um_serial_addsub;

    logic clk;
    logic rst_n;
    logic ena;

    tt_um_serial_addsub_if bus_if ();

    tt_um_serial_addsub #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec;
    int n_err;
    int edges;
    int done_at;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] pack(input logic a, input logic b,
                                        input logic v, input logic st,
                                        input logic sub);
        return {3'b000, sub, st, v, b, a};
    endfunction

    // One clock; records the first edge (counted from the start edge) at
    // which done is seen.
    task automatic tick();
        @(posedge clk);
        #1;
        edges++;
        if (done_at < 0 && bus_if.uio_out[0] === 1'b1) done_at = edges;
    endtask

    // Runs one operation. start rises on the first counted edge together
    // with a bit_valid that must not be consumed. Optional: gap cycles
    // between bits, start held high, start re-pulsed at a bit index, and a
    // 5-cycle ena-low window (with bit_valid high) before a bit index.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                          input logic sub, input int gap, input logic hold,
                          input int repulse_at, input int ena_low_at,
                          input logic [7:0] exp_part);
        bus_if.ui_in = pack(1'b0, 1'b0, 1'b0, 1'b0, sub);
        @(posedge clk);
        #1;
        edges   = 0;
        done_at = -1;
        bus_if.ui_in = pack(a[0], b[0], 1'b1, 1'b1, sub);
        tick();
        check("busy_after_start", {29'd0, bus_if.uio_out[2:0]}, 32'h4);
        check("result_cleared", {24'd0, bus_if.uo_out}, 32'h0);
        for (int i = 0; i < 8; i++) begin
            if (i == ena_low_at) begin
                ena = 1'b0;
                bus_if.ui_in = pack(~a[i], ~b[i], 1'b1, hold, sub);
                repeat (5) tick();
                check("ena_low_uo", {24'd0, bus_if.uo_out}, {24'd0, exp_part});
                check("ena_low_busy", {31'd0, bus_if.uio_out[2]}, 32'h1);
                ena = 1'b1;
            end
            bus_if.ui_in = pack(a[i], b[i], 1'b1, (i == repulse_at) | hold, sub);
            tick();
            if (gap > 0 && i < 7) begin
                bus_if.ui_in = pack(a[i], b[i], 1'b0, hold, sub);
                repeat (gap) tick();
            end
        end
        bus_if.ui_in = pack(1'b0, 1'b0, 1'b0, hold, sub);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        edges = 0;
        done_at = -1;
        rst_n = 1'b0;
        ena   = 1'b1;
        bus_if.ui_in  = 8'h00;
        bus_if.uio_in = 8'h00;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_uo_out", {24'd0, bus_if.uo_out}, 32'h0);
        check("rst_uio_out", {24'd0, bus_if.uio_out}, 32'h0);
        check("uio_oe", {24'd0, bus_if.uio_oe}, 32'h0F);
        rst_n = 1'b1;
        tick();

        // 0x35 + 0x4A
        run_op(8'h35, 8'h4A, 1'b0, 0, 1'b0, -1, -1, 8'h00);
        check("add1_uo", {24'd0, bus_if.uo_out}, 32'h7F);
        check("add1_flags", {28'd0, bus_if.uio_out[3:0]}, 32'h1);
        check("add1_latency", done_at, 9);

        // 0xFF + 0x01
        run_op(8'hFF, 8'h01, 1'b0, 0, 1'b0, -1, -1, 8'h00);
        check("add2_uo", {24'd0, bus_if.uo_out}, 32'h00);
        check("add2_flags", {28'd0, bus_if.uio_out[3:0]}, 32'h3);

        // 0x10 - 0x01
        run_op(8'h10, 8'h01, 1'b1, 0, 1'b0, -1, -1, 8'h00);
        check("sub1_uo", {24'd0, bus_if.uo_out}, 32'h0F);
        check("sub1_flags", {28'd0, bus_if.uio_out[3:0]}, 32'h1);

        // 0x01 - 0x02 with 3-cycle gaps
        run_op(8'h01, 8'h02, 1'b1, 3, 1'b0, -1, -1, 8'h00);
        check("sub2_uo", {24'd0, bus_if.uo_out}, 32'hFF);
        check("sub2_flags", {28'd0, bus_if.uio_out[3:0]}, 32'hB);
        check("sub2_latency", done_at, 30);

        // bit_valid in DONE is ignored
        bus_if.ui_in = pack(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (3) tick();
        check("done_hold_uo", {24'd0, bus_if.uo_out}, 32'hFF);
        check("done_hold_flags", {28'd0, bus_if.uio_out[3:0]}, 32'hB);

        // start re-pulsed at bit 4: 0x5A + 0x33
        run_op(8'h5A, 8'h33, 1'b0, 0, 1'b0, 4, -1, 8'h00);
        check("repulse_uo", {24'd0, bus_if.uo_out}, 32'h8D);
        check("repulse_flags", {28'd0, bus_if.uio_out[3:0]}, 32'h9);
        check("repulse_latency", done_at, 9);

        // rst_n pulsed at bit 5 of an add
        bus_if.ui_in = pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        bus_if.ui_in = pack(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        for (int i = 0; i < 5; i++) begin
            bus_if.ui_in = pack(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
            tick();
        end
        check("pre_rst_busy", {31'd0, bus_if.uio_out[2]}, 32'h1);
        rst_n = 1'b0;
        #1;
        check("midrst_uo", {24'd0, bus_if.uo_out}, 32'h0);
        check("midrst_uio", {24'd0, bus_if.uio_out}, 32'h0);
        tick();
        rst_n = 1'b1;
        bus_if.ui_in = pack(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        repeat (2) tick();
        check("idle_valid_ignored", {24'd0, bus_if.uio_out}, 32'h0);
        run_op(8'h12, 8'h34, 1'b0, 0, 1'b0, -1, -1, 8'h00);
        check("after_rst_uo", {24'd0, bus_if.uo_out}, 32'h46);
        check("after_rst_flags", {28'd0, bus_if.uio_out[3:0]}, 32'h1);

        // 0xC3 + 0x5A reference run, then with ena low before bit 3
        run_op(8'hC3, 8'h5A, 1'b0, 0, 1'b0, -1, -1, 8'h00);
        check("ena_ref_uo", {24'd0, bus_if.uo_out}, 32'h1D);
        check("ena_ref_flags", {28'd0, bus_if.uio_out[3:0]}, 32'h3);
        run_op(8'hC3, 8'h5A, 1'b0, 0, 1'b0, -1, 3, 8'hA0);
        check("ena_uo", {24'd0, bus_if.uo_out}, 32'h1D);
        check("ena_flags", {28'd0, bus_if.uio_out[3:0]}, 32'h3);
        check("ena_latency", done_at, 14);

        // start held high throughout: 0xA0 + 0x70, no retrigger after DONE
        run_op(8'hA0, 8'h70, 1'b0, 0, 1'b1, -1, -1, 8'h00);
        check("hold_uo", {24'd0, bus_if.uo_out}, 32'h10);
        check("hold_flags", {28'd0, bus_if.uio_out[3:0]}, 32'h3);
        repeat (3) tick();
        check("hold_no_retrig", {28'd0, bus_if.uio_out[3:0]}, 32'h3);
        check("hold_uo_kept", {24'd0, bus_if.uo_out}, 32'h10);

        // Restart from DONE: done drops after the start edge
        bus_if.ui_in = pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        bus_if.ui_in = pack(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        check("restart_status", {29'd0, bus_if.uio_out[2:0]}, 32'h4);
        check("restart_uo", {24'd0, bus_if.uo_out}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/tt_um_serial_addsub.md
# tt_um_serial_addsub

Bit-serial add/subtract unit on the standard Tiny Tapeout pin interface. It is the sequential, two-direction counterpart to our combinational half adder. Operands stream in LSB-first, one bit pair per qualified clock. The block accumulates a WIDTH-bit sum or difference with carry/borrow and presents it on the dedicated outputs, with done/busy status on the bidirectional pins.

## Interface
- WIDTH, 8, operand/result width; legal 1..8 (bounded by uo_out).
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- ena  in  1  design enable; low = stall (no state, counter or register advances)
- ui_in  in  8  [0] a bit, [1] b bit, [2] bit_valid, [3] start, [4] sub (1 = a−b), [7:5] unused
- uo_out  out  8  result register, zero-extended above WIDTH
- uio_in  in  8  unused
- uio_out  out  8  [0] done, [1] cout (carry for add, borrow for sub), [2] busy, [3] last sum bit, [7:4] = 0
- uio_oe  out  8  constant 8'b0000_1111

## Operation
- States: IDLE, BUSY, DONE; encoded in registers, reset to IDLE.
- start is edge-detected against a registered copy: start_rise = start & ~start_q.
- IDLE or DONE, start_rise:
  - Go to BUSY.
  - Latch mode = sub.
  - Clear result, bit counter and done.
  - Carry init = mode (0 add, 1 sub).
- BUSY, bit_valid = 1:
  - b' = b ^ mode; s = a ^ b' ^ c; c <= majority(a, b', c).
  - result <= {s, result[WIDTH-1:1]} (right shift, LSB-first fill).
  - Last-sum register <= s; count++.
- BUSY, bit_valid = 0: hold everything (gaps allowed, any length).
- On the bit making count == WIDTH:
  - Go to DONE. done = 1, busy = 0.
  - cout = c_next for add, ~c_next for sub.
- DONE holds result/cout/done until the next start_rise. bit_valid in IDLE/DONE is ignored.
- start_rise in BUSY is ignored; the operation continues.
- ena = 0 freezes all registers, including start_q, so no edge is lost or invented.
- Width rules:
  - Result is modulo 2^WIDTH.
  - Sub uses two's complement a + ~b + 1.
  - Borrow = 1 iff a < b (unsigned).

## Timing
- Reset (async assert, sync-safe deassert): uo_out = 0, uio_out = 0, state IDLE, carry 0, count 0, start_q 0.
- start_rise sampled at edge k: busy = 1 after edge k. A bit_valid at edge k is not consumed.
- First bit is consumed at edge k+1 at the earliest.
- Minimum latency start → done: WIDTH+1 edges.
- done/cout/uo_out final values are visible after the edge consuming bit WIDTH. No extra cycle.
- uo_out shows partial shifted result during BUSY. It is valid only while done = 1.
- Reset mid-BUSY aborts immediately to IDLE with all outputs 0.
- Back-to-back: start_rise at the same edge done is shown (DONE state) starts the next operation. done drops after that edge.

## Configuration
- INPUT_SYNC_EN defined: ui_in[4:0] pass through 2-flop synchronizers (reset 0) before all logic. Every input-referenced latency grows by 2 edges.
- Not defined: ui_in used directly; the host must drive inputs synchronously to clk.

## Test plan
- Add 0x35 + 0x4A, 8 consecutive valid bits → done after edge 9 from start; uo_out = 0x7F, cout = 0.
- Add 0xFF + 0x01 → uo_out = 0x00, cout = 1; sum bit last = 0.
- Sub 0x10 − 0x01 → uo_out = 0x0F, borrow 0.
- Sub 0x01 − 0x02, with bit_valid gaps of 3 cycles between bits → uo_out = 0xFF, borrow 1. Latency = 8 + gaps + 1.
- start re-pulsed at bit 4 of an add: ignored, result unchanged. rst_n pulsed at bit 5: all outputs 0, state IDLE; the next operation completes correctly.
- ena low for 5 cycles mid-BUSY with bit_valid high → no bits consumed. Result identical to the ena-always-high run. Held-high start does not retrigger after DONE.
